bcd_text_formatter: RTL and testbench
=====================================

// Module: bcd_text_formatter
// PURPOSE
//  Consumes the 24-bit packed BCD result of the 6-digit lag counter and streams it as
//  ASCII characters ("DDD.DDD") into the OSD/text character buffer over a valid/ready
//  link. It blanks leading zeros, inserts the decimal point and flags non-BCD digits.
//  It sits between the BCD counter and the text RAM writer.
// PARAMETERS
//  FRAC_DIGITS    3   digits after the decimal point, 0..5; 0 = no point emitted
//  BLANK_LEADING  1   1 = leading zeros of the integer part shown as space (0x20)
//  ADDR_WIDTH     5   width of char_addr
//  BASE_ADDR      0   char_addr of the first (leftmost) emitted character
// PORTS
//  clock       in   1            system clock, all logic on its rising edge
//  reset       in   1            asynchronous, active-high reset
//  start       in   1            1-cycle request: capture bcd_in and emit it
//  bcd_in      in   24           {d5..d0} packed BCD, d5 = most significant digit
//  char_data   out  8            ASCII character
//  char_addr   out  ADDR_WIDTH   BASE_ADDR + character index
//  char_valid  out  1            char_data/char_addr valid
//  char_ready  in   1            sink accepts when char_valid && char_ready
//  busy        out  1            high from capture until done
//  done        out  1            1-cycle pulse after the last character is accepted
// BEHAVIOUR
//  - Reset (async): state IDLE; char_valid=0, busy=0, done=0, char_data=0x00,
//    char_addr=BASE_ADDR; captured value cleared to 0.
//  - FSM IDLE -> EMIT -> DONE -> IDLE.
//    IDLE: on start, latch bcd_in, set idx=0, go to EMIT; busy=1 from the next cycle.
//    EMIT: char_valid=1 with the character for idx. On valid&&ready, idx+1. On the
//    last index, go to DONE.
//    DONE: done=1, busy=0, char_valid=0 for exactly one cycle, then IDLE.
//  - Character count N = 6 + (FRAC_DIGITS>0). Index 0 is leftmost. The point (0x2E)
//    sits at index 6-FRAC_DIGITS, between the integer and fraction digits.
//  - Digit v in 0..9 maps to 0x30+v. A digit >9 maps to '?' (0x3F).
//  - Blanking applies when BLANK_LEADING=1. An integer-part digit is emitted as 0x20
//    if it and every more-significant digit equal 0. The units digit (last integer
//    digit) is never blanked. A '?' ends blanking. Fraction digits are never blanked.
//  - The first char_valid appears 1 cycle after start is sampled. With ready held
//    high, 1 char/cycle, and done rises N+1 cycles after start.
//  - While char_valid=1 and char_ready=0, char_data and char_addr hold stable.
//  - start is ignored outside IDLE, and bcd_in changes after capture have no effect.
//    start in the DONE cycle is ignored.
//  - Reset mid-stream aborts immediately. No done pulse, and no further characters.
//  - char_addr = BASE_ADDR+idx, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
// TESTING
//  1 FRAC=3, bcd_in=24'h012345, ready=1 -> 20 31 32 2E 33 34 35 at addr 0..6;
//    done 8 cycles after start.
//  2 bcd_in=24'h000007 -> 20 20 30 2E 30 30 37; 24'h999999 -> 39 39 39 2E 39 39 39.
//  3 bcd_in=24'h00A000 -> 20 20 3F 2E 30 30 30; 24'h0A0000 -> 20 3F 30 2E 30 30 30.
//  4 Backpressure: ready=0 for 3 cycles at idx 2 -> 0x32/addr 2 held stable;
//    stream then resumes and completes.
//  5 start pulsed during EMIT with a new bcd_in -> ignored, original value completes;
//    BASE_ADDR=30, ADDR_WIDTH=5 -> addrs 30,31,0,1..4.
//  6 reset asserted at idx 3 -> char_valid/busy low immediately, no done; a fresh
//    start then emits from idx 0. FRAC=0 -> 6 chars, no point.

Source files
------------

// File: rtl/bcd_text_formatter.sv
// Streams a captured 6-digit packed BCD value as ASCII "DDD.DDD" over a valid/ready
// character link, blanking leading integer zeros and flagging non-BCD digits as '?'.
module bcd_text_formatter #(
  parameter int FRAC_DIGITS   = 3,
  parameter int BLANK_LEADING = 1,
  parameter int ADDR_WIDTH    = 5,
  parameter int BASE_ADDR     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [23:0]           bcd_in,
  output logic [7:0]            char_data,
  output logic [ADDR_WIDTH-1:0] char_addr,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic                  busy,
  output logic                  done
);

  localparam bit         HAS_POINT = FRAC_DIGITS > 0;
  localparam int         NCHARS    = HAS_POINT ? 7 : 6;
  localparam logic [2:0] LAST_IDX  = 3'(NCHARS - 1);
  localparam logic [2:0] POINT_IDX = 3'(6 - FRAC_DIGITS);
  localparam logic [2:0] UNITS_POS = 3'(FRAC_DIGITS);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [23:0] value;
  logic [2:0]  idx, idx_nxt;
  logic [3:0]  digit [6];
  logic [6:0]  lead_zero;
  logic [2:0]  pos;
  logic [3:0]  cur;
  logic        accept;

  assign accept = char_valid && char_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      value <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == IDLE && start) value <= bcd_in;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (start) begin
        state_nxt = EMIT;
        idx_nxt   = '0;
      end
      EMIT: if (accept) begin
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // lead_zero[k]: digit k and every more-significant digit are zero
  always_comb begin
    lead_zero[6] = 1'b1;
    for (int j = 0; j < 6; j++) digit[j] = value[4*j +: 4];
    for (int j = 5; j >= 0; j--) lead_zero[j] = lead_zero[j+1] && (digit[j] == 4'd0);
  end

  always_comb begin
    pos = 3'd5 - idx;
    if (HAS_POINT && idx > POINT_IDX) pos = 3'd6 - idx;
    cur       = digit[pos];
    char_data = 8'h00;
    if (state == EMIT) begin
      if (HAS_POINT && idx == POINT_IDX)                                char_data = 8'h2E;
      else if (cur > 4'd9)                                             char_data = 8'h3F;
      else if (BLANK_LEADING != 0 && pos > UNITS_POS && lead_zero[pos]) char_data = 8'h20;
      else                                                             char_data = 8'h30 + {4'h0, cur};
    end
  end

  assign char_addr  = ADDR_WIDTH'(BASE_ADDR + int'(idx));
  assign char_valid = (state == EMIT);
  assign busy       = (state == EMIT);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_bcd_text_formatter.sv
// Randomized bench for bcd_text_formatter: three configurations share one stimulus
// stream and are compared against a string-building reference model.
module tb_bcd_text_formatter;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, char_ready = 1'b1;
  logic [23:0] bcd_in = '0;
  logic [7:0]  cd [3];
  logic [4:0]  ca [3];
  logic        cv [3], bz [3], dn [3];

  localparam int FR [3] = '{3, 1, 0};
  localparam int BL [3] = '{1, 0, 1};
  localparam int BA [3] = '{0, 30, 0};
  localparam int NC [3] = '{7, 7, 6};

  int vectors = 0, miscompares = 0;

  logic [7:0] od [3][$];
  logic [4:0] oa [3][$];
  int         done_k [3], done_n [3];
  bit         first_ok [3];
  bit         held_ok;
  logic [7:0] hd;
  logic [4:0] ha;

  always #5 clock = ~clock;

  bcd_text_formatter #(.FRAC_DIGITS(3), .BLANK_LEADING(1), .ADDR_WIDTH(5), .BASE_ADDR(0)) u0 (
    .clock(clock), .reset(reset), .start(start), .bcd_in(bcd_in), .char_data(cd[0]),
    .char_addr(ca[0]), .char_valid(cv[0]), .char_ready(char_ready), .busy(bz[0]), .done(dn[0]));
  bcd_text_formatter #(.FRAC_DIGITS(1), .BLANK_LEADING(0), .ADDR_WIDTH(5), .BASE_ADDR(30)) u1 (
    .clock(clock), .reset(reset), .start(start), .bcd_in(bcd_in), .char_data(cd[1]),
    .char_addr(ca[1]), .char_valid(cv[1]), .char_ready(char_ready), .busy(bz[1]), .done(dn[1]));
  bcd_text_formatter #(.FRAC_DIGITS(0), .BLANK_LEADING(1), .ADDR_WIDTH(5), .BASE_ADDR(0)) u2 (
    .clock(clock), .reset(reset), .start(start), .bcd_in(bcd_in), .char_data(cd[2]),
    .char_addr(ca[2]), .char_valid(cv[2]), .char_ready(char_ready), .busy(bz[2]), .done(dn[2]));

  // Builds the whole display string left to right, then returns character i.
  function automatic logic [7:0] model_char(int frac, int blank, logic [23:0] v, int i);
    logic [7:0] s [$];
    bit         lead;
    int         nint, dg;
    logic [7:0] g;
    lead = 1'b1;
    nint = 6 - frac;
    for (int p = 0; p < 6; p++) begin
      dg = int'((v >> (4 * (5 - p))) & 24'hF);
      g  = (dg > 9) ? 8'h3F : 8'(8'h30 + dg);
      if (frac > 0 && p == nint) s.push_back(8'h2E);
      if (p < nint && blank != 0 && lead && dg == 0 && p != nint - 1) s.push_back(8'h20);
      else begin
        if (p < nint) lead = 1'b0;
        s.push_back(g);
      end
    end
    return s[i];
  endfunction

  function automatic logic [23:0] rand_bcd();
    logic [23:0] r;
    for (int j = 0; j < 6; j++)
      r[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  // Runs one capture/stream, recording accepted characters and done timing per DUT.
  task automatic capture(input logic [23:0] v, input int stall_at, input int stall_len, input bit poke);
    int stalled;
    stalled = 0; held_ok = 1'b1; hd = '0; ha = '0;
    for (int d = 0; d < 3; d++) begin
      od[d].delete(); oa[d].delete(); done_k[d] = -1; done_n[d] = 0; first_ok[d] = 1'b0;
    end
    @(negedge clock); bcd_in = v; start = 1'b1; char_ready = 1'b1;
    @(posedge clock);
    for (int k = 0; k < NC[0] + stall_len + 4; k++) begin
      @(negedge clock);
      start  = (poke && (k == 2 || k == 6));
      bcd_in = 24'($urandom());
      char_ready = 1'b1;
      if (stall_len > 0 && od[0].size() == stall_at && stalled < stall_len) begin
        char_ready = 1'b0;
        if (stalled == 0) begin hd = cd[0]; ha = ca[0]; end
        else if (cd[0] !== hd || ca[0] !== ha || cv[0] !== 1'b1) held_ok = 1'b0;
        stalled++;
      end
      for (int d = 0; d < 3; d++) begin
        if (k == 0) first_ok[d] = (cv[d] === 1'b1 && bz[d] === 1'b1);
        if (cv[d] === 1'b1 && char_ready) begin od[d].push_back(cd[d]); oa[d].push_back(ca[d]); end
        if (dn[d] === 1'b1) begin
          if (done_k[d] < 0) done_k[d] = k;
          done_n[d]++;
        end
      end
    end
    start = 1'b0;
    char_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (cv[d] !== 1'b0 || bz[d] !== 1'b0 || dn[d] !== 1'b0 || cd[d] !== 8'h00 || ca[d] !== 5'(BA[d])) begin
        miscompares++;
        $display("FAIL reset dut%0d got v=%b b=%b d=%b data=%h addr=%0d want 0 0 0 00 %0d",
                 d, cv[d], bz[d], dn[d], cd[d], ca[d], BA[d]);
      end
    end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_patterns();
    logic [23:0] vals [$];
    vals = '{24'h012345, 24'h000007, 24'h999999, 24'h00A000, 24'h0A0000, 24'h000000, 24'hF00000};
    repeat (12) vals.push_back(rand_bcd());
    foreach (vals[n]) begin
      capture(vals[n], 0, 0, 1'b0);
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (!first_ok[d] || od[d].size() != NC[d]) begin
          miscompares++;
          $display("FAIL pat_start dut%0d v=%h first=%b count=%0d want first=1 count=%0d",
                   d, vals[n], first_ok[d], od[d].size(), NC[d]);
        end
        for (int i = 0; i < od[d].size() && i < NC[d]; i++) begin
          vectors++;
          if (od[d][i] !== model_char(FR[d], BL[d], vals[n], i) || oa[d][i] !== 5'((BA[d] + i) % 32)) begin
            miscompares++;
            $display("FAIL pat_char dut%0d v=%h idx=%0d got %h@%0d want %h@%0d", d, vals[n], i,
                     od[d][i], oa[d][i], model_char(FR[d], BL[d], vals[n], i), (BA[d] + i) % 32);
          end
        end
        vectors++;
        if (done_k[d] != NC[d] || done_n[d] != 1) begin
          miscompares++;
          $display("FAIL pat_done dut%0d v=%h at=%0d pulses=%0d want at=%0d pulses=1",
                   d, vals[n], done_k[d], done_n[d], NC[d]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] v;
    int          at, len;
    for (int n = 0; n < 6; n++) begin
      v   = (n == 0) ? 24'h012345 : rand_bcd();
      at  = (n == 0) ? 2 : $urandom_range(0, 5);
      len = (n == 0) ? 3 : $urandom_range(1, 4);
      capture(v, at, len, 1'b0);
      vectors++;
      if (!held_ok || hd !== model_char(FR[0], BL[0], v, at) || ha !== 5'(at)) begin
        miscompares++;
        $display("FAIL bp_hold v=%h idx=%0d got %h@%0d stable=%b want %h@%0d stable=1",
                 v, at, hd, ha, held_ok, model_char(FR[0], BL[0], v, at), at);
      end
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < od[d].size() && i < NC[d]; i++) begin
          vectors++;
          if (od[d][i] !== model_char(FR[d], BL[d], v, i) || oa[d][i] !== 5'((BA[d] + i) % 32)) begin
            miscompares++;
            $display("FAIL bp_char dut%0d v=%h idx=%0d got %h@%0d want %h@%0d", d, v, i,
                     od[d][i], oa[d][i], model_char(FR[d], BL[d], v, i), (BA[d] + i) % 32);
          end
        end
        vectors++;
        if (od[d].size() != NC[d] || done_k[d] != NC[d] + len || done_n[d] != 1) begin
          miscompares++;
          $display("FAIL bp_done dut%0d v=%h count=%0d at=%0d pulses=%0d want %0d %0d 1",
                   d, v, od[d].size(), done_k[d], done_n[d], NC[d], NC[d] + len);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [23:0] v;
    for (int n = 0; n < 4; n++) begin
      v = (n == 0) ? 24'h000123 : rand_bcd();
      capture(v, 0, 0, 1'b1);
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (od[d].size() != NC[d] || done_n[d] != 1) begin
          miscompares++;
          $display("FAIL poke_count dut%0d v=%h count=%0d pulses=%0d want %0d 1",
                   d, v, od[d].size(), done_n[d], NC[d]);
        end
        for (int i = 0; i < od[d].size() && i < NC[d]; i++) begin
          vectors++;
          if (od[d][i] !== model_char(FR[d], BL[d], v, i) || oa[d][i] !== 5'((BA[d] + i) % 32)) begin
            miscompares++;
            $display("FAIL poke_char dut%0d v=%h idx=%0d got %h@%0d want %h@%0d", d, v, i,
                     od[d][i], oa[d][i], model_char(FR[d], BL[d], v, i), (BA[d] + i) % 32);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    bit          quiet;
    logic [23:0] v;
    @(negedge clock); bcd_in = 24'h456789; start = 1'b1; char_ready = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (cv[d] !== 1'b0 || bz[d] !== 1'b0 || dn[d] !== 1'b0 || ca[d] !== 5'(BA[d])) begin
        miscompares++;
        $display("FAIL abort_now dut%0d got v=%b b=%b d=%b addr=%0d want 0 0 0 %0d",
                 d, cv[d], bz[d], dn[d], ca[d], BA[d]);
      end
    end
    @(negedge clock); reset = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) if (cv[d] !== 1'b0 || dn[d] !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL abort_quiet got activity=1 want activity=0");
    end
    v = rand_bcd();
    capture(v, 0, 0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (od[d].size() != NC[d] || od[d][0] !== model_char(FR[d], BL[d], v, 0) || oa[d][0] !== 5'(BA[d])) begin
        miscompares++;
        $display("FAIL abort_restart dut%0d v=%h count=%0d first=%h@%0d want %0d %h@%0d", d, v,
                 od[d].size(), od[d][0], oa[d][0], NC[d], model_char(FR[d], BL[d], v, 0), BA[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_backpressure();
    test_start_ignored();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
